uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter among `NUM_REQ` byte-producing requesters. It accepts one byte per grant over a valid/ready handshake and launches it into the transmitter with a one-cycle data-valid strobe. It then tracks the transmitter's busy flag until the frame completes, and flags a transmitter that never starts. It sits between on-chip producers and the TX path's `P_DATA`/`Data_Valid`/`Busy` ports, in the TX clock domain.

## Interface
- `NUM_REQ`, default 4: number of requesters (2..16).
- `DATA_SIZE`, default 8: byte width.
- `BUSY_TIMEOUT`, default 4: cycles allowed after launch for `TX_BUSY` to rise (≥2).

Ports:
- `CLK`  in  1  single clock, the TX clock.
- `RST`  in  1  reset, synchronous, active-low.
- `REQ_VALID`  in  NUM_REQ  per-requester byte valid.
- `REQ_DATA`  in  NUM_REQ*DATA_SIZE  packed bytes; requester i occupies bits [i*DATA_SIZE +: DATA_SIZE].
- `REQ_READY`  out  NUM_REQ  per-requester accept; one-hot or zero.
- `TX_P_DATA`  out  DATA_SIZE  byte to transmitter, registered.
- `TX_DATA_VALID`  out  1  one-cycle launch strobe to transmitter.
- `TX_BUSY`  in  1  transmitter busy flag.
- `GNT_ID`  out  $clog2(NUM_REQ)  index of the requester currently being served, registered.
- `ACTIVE`  out  1  high from launch until the frame is done or aborted.
- `TX_ERR`  out  1  one-cycle pulse on busy timeout.

## Operation
- Handshake: a byte transfers on a rising edge where `REQ_VALID[i]` and `REQ_READY[i]` are both 1. The requester holds valid and data stable until it is accepted. Deasserting valid before acceptance withdraws the request.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - When `TX_BUSY`=0 and any valid is set, the winner is the first set bit searching upward from `ptr+1` modulo NUM_REQ.
  - `REQ_READY[winner]`=1 combinationally in that cycle.
  - On the edge: latch the byte into `TX_P_DATA`, load `GNT_ID` and `ptr` with the winner, and go to LAUNCH.
  - When `TX_BUSY`=1, no grant is made.
- LAUNCH:
  - `TX_DATA_VALID`=1 for exactly this cycle and `ACTIVE`=1.
  - Clear the timeout counter and go to WAIT_BUSY.
- WAIT_BUSY:
  - If `TX_BUSY`=1, go to WAIT_DONE.
  - Otherwise increment the counter. When it reaches BUSY_TIMEOUT, pulse `TX_ERR` for one cycle and go to IDLE. The byte is dropped and not retried.
- WAIT_DONE:
  - Stay while `TX_BUSY`=1.
  - On `TX_BUSY`=0, go to IDLE. `ACTIVE` drops in the IDLE cycle.
- `REQ_READY` is 0 in every state except IDLE.
- `TX_P_DATA` and `GNT_ID` hold their values until the next grant.
- `ptr` advances only on a grant. This guarantees each requester that keeps valid set is served within NUM_REQ frames.

## Timing
- Reset (`RST`=0 at an edge) forces:
  - all outputs to 0, `TX_P_DATA`=0, `GNT_ID`=0;
  - state=IDLE, `ptr`=NUM_REQ-1, so requester 0 has first priority;
  - counter=0.
- Reset mid-frame aborts at once: no `TX_ERR`, and the byte is lost.
- Latency: acceptance edge at cycle N, then `TX_DATA_VALID` high during cycle N+1.
- Back-to-back: a new grant is possible in the first IDLE cycle after `TX_BUSY` falls, i.e. the cycle after WAIT_DONE sees busy=0.
- Simultaneous requests resolve by round-robin order only. There is no fixed priority beyond the reset pointer.
- The timeout counter is $clog2(BUSY_TIMEOUT+1) bits wide, saturates, and cannot wrap.
- `TX_BUSY` rising in the LAUNCH cycle itself is ignored. WAIT_BUSY samples it on the next cycle.

## Structure
- Package `uart_ctrl_pkg` holds:
  - the state enum `tx_arb_state_t` (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE);
  - a `GNT_W` function for $clog2 with a minimum width of 1.
- Sub-module `rr_arbiter`: purely combinational. Inputs are request vector and `ptr`; outputs are one-hot grant, grant index, and any-request. Parameterised by NUM_REQ.
- The top contains the FSM, the data/ID registers and the timeout counter.

## Test plan
- Single request, with a TX model that raises busy 1 cycle after strobe and holds it 11 cycles. Requester 2 sends 0xA5: `REQ_READY[2]` pulses once; `TX_DATA_VALID` is 1 for 1 cycle with `TX_P_DATA`=0xA5 and `GNT_ID`=2; `ACTIVE` stays high until busy falls.
- All 4 requesters hold valid after reset, 8 frames: grants are issued in order 0,1,2,3,0,1,2,3, each byte launched exactly once.
- TX model never raises busy with BUSY_TIMEOUT=4: `TX_ERR` pulses 4 cycles after WAIT_BUSY entry, FSM returns to IDLE, and the next request is granted normally.
- `TX_BUSY` held externally at 1 in IDLE with requests pending: no `REQ_READY` and no strobe; grant follows the cycle after busy drops.
- `RST` asserted during WAIT_DONE: all outputs 0 next cycle; after release, requester 0 wins against requester 3.
- Requester 1 withdraws valid before acceptance while requester 3 is valid: requester 3 is granted and requester 1 never sees ready.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: shared FSM state type and grant-width helper for the UART TX arbiter
package uart_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} tx_arb_state_t;
    function automatic int GNT_W(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr+1
module rr_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int GW = GNT_W(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [GW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [GW-1:0]      idx_o,
    output logic               any_o
);
    always_comb begin
        logic found;
        logic [GW-1:0] j;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = GW'((int'(ptr_i) + k) % NUM_REQ);
            if (!found && req_i[j]) begin
                found = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o = j;
            end
        end
        any_o = |req_i;
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter with launch strobe and busy-timeout tracking
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_SIZE = 8,
    parameter int BUSY_TIMEOUT = 4,
    localparam int GW = GNT_W(NUM_REQ),
    localparam int CW = $clog2(BUSY_TIMEOUT + 1)
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [NUM_REQ-1:0]             REQ_VALID,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   REQ_DATA,
    output logic [NUM_REQ-1:0]             REQ_READY,
    output logic [DATA_SIZE-1:0]           TX_P_DATA,
    output logic                           TX_DATA_VALID,
    input  logic                           TX_BUSY,
    output logic [GW-1:0]                  GNT_ID,
    output logic                           ACTIVE,
    output logic                           TX_ERR
);
    tx_arb_state_t        state_q;
    logic [GW-1:0]        ptr_q, gnt_id_q, idx;
    logic [DATA_SIZE-1:0] data_q, sel;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   gnt;
    logic                 dv_q, active_q, err_q, any, grant;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_i (REQ_VALID),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (idx),
        .any_o (any)
    );

    always_comb begin
        grant = state_q == IDLE && !TX_BUSY && any;
        REQ_READY = grant ? gnt : '0;
        cnt_d = (cnt_q == CW'(BUSY_TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
        sel = '0;
        for (int i = 0; i < NUM_REQ; i++) sel = gnt[i] ? REQ_DATA[i*DATA_SIZE +: DATA_SIZE] : sel;
        TX_P_DATA = data_q;
        TX_DATA_VALID = dv_q;
        GNT_ID = gnt_id_q;
        ACTIVE = active_q;
        TX_ERR = err_q;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= IDLE;
            ptr_q    <= GW'(NUM_REQ - 1);
            gnt_id_q <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            dv_q     <= 1'b0;
            active_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            dv_q  <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                IDLE: if (grant) begin
                    data_q   <= sel;
                    gnt_id_q <= idx;
                    ptr_q    <= idx;
                    dv_q     <= 1'b1;
                    active_q <= 1'b1;
                    state_q  <= LAUNCH;
                end
                LAUNCH: begin
                    cnt_q   <= '0;
                    state_q <= WAIT_BUSY;
                end
                WAIT_BUSY: if (TX_BUSY) state_q <= WAIT_DONE;
                else begin
                    cnt_q <= cnt_d;
                    // a transmitter that never starts drops the byte
                    if (cnt_d == CW'(BUSY_TIMEOUT)) begin
                        err_q    <= 1'b1;
                        active_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                WAIT_DONE: if (!TX_BUSY) begin
                    active_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios against a simple TX busy model
module tb_uart_tx_arbiter;
    logic        clk, rst_n;
    logic [3:0]  req_valid, req_ready;
    logic [31:0] req_data;
    logic [7:0]  data [4];
    logic [7:0]  tx_p_data;
    logic        tx_dv, tx_busy, active, tx_err;
    logic [1:0]  gnt_id;
    logic        force_busy, no_busy, model_busy;
    int          busy_left;
    int          vectors, fails, cyc;
    int          n_launch, err_cnt, err_cyc;
    int          rdy_cnt [4];
    logic [7:0]  log_data [64];
    logic [1:0]  log_id [64];
    int          log_cyc [64];

    uart_tx_arbiter #(.NUM_REQ(4), .DATA_SIZE(8), .BUSY_TIMEOUT(4)) dut (
        .CLK           (clk),
        .RST           (rst_n),
        .REQ_VALID     (req_valid),
        .REQ_DATA      (req_data),
        .REQ_READY     (req_ready),
        .TX_P_DATA     (tx_p_data),
        .TX_DATA_VALID (tx_dv),
        .TX_BUSY       (tx_busy),
        .GNT_ID        (gnt_id),
        .ACTIVE        (active),
        .TX_ERR        (tx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb req_data = {data[3], data[2], data[1], data[0]};

    // transmitter model: busy rises the cycle after the strobe and lasts 11 cycles
    assign model_busy = busy_left != 0;
    assign tx_busy = model_busy | force_busy;
    always @(posedge clk) begin
        if (tx_dv && !no_busy) busy_left <= 11;
        else if (busy_left > 0) busy_left <= busy_left - 1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_dv && n_launch < 64) begin
                log_data[n_launch] <= tx_p_data;
                log_id[n_launch]   <= gnt_id;
                log_cyc[n_launch]  <= cyc;
            end
            if (tx_dv) n_launch <= n_launch + 1;
            if (tx_err) begin
                err_cnt <= err_cnt + 1;
                err_cyc <= cyc;
            end
            for (int i = 0; i < 4; i++) if (req_ready[i]) rdy_cnt[i] <= rdy_cnt[i] + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            done = !active && !tx_busy;
            tick();
        end
        vectors++;
        if (!done) begin fails++; $display("FAIL %s_idle_timeout active=%b busy=%b required idle", name, active, tx_busy); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '0;
        for (int i = 0; i < 4; i++) data[i] = '0;
        tick();
        tick();
        @(negedge clk);
        vectors++; if (tx_dv !== 1'b0)      begin fails++; $display("FAIL reset_dv got=%b exp=0", tx_dv); end
        vectors++; if (active !== 1'b0)     begin fails++; $display("FAIL reset_active got=%b exp=0", active); end
        vectors++; if (tx_err !== 1'b0)     begin fails++; $display("FAIL reset_err got=%b exp=0", tx_err); end
        vectors++; if (tx_p_data !== 8'h00) begin fails++; $display("FAIL reset_data got=%h exp=00", tx_p_data); end
        vectors++; if (gnt_id !== 2'd0)     begin fails++; $display("FAIL reset_gnt_id got=%0d exp=0", gnt_id); end
        vectors++; if (req_ready !== 4'b0)  begin fails++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int n0, r0, act;
        n0 = n_launch;
        r0 = rdy_cnt[2];
        data[2] = 8'hA5;
        req_valid[2] = 1'b1;
        @(negedge clk);
        vectors++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
        tick();
        req_valid[2] = 1'b0;
        @(negedge clk);
        vectors++; if (tx_dv !== 1'b1)      begin fails++; $display("FAIL single_dv got=%b exp=1", tx_dv); end
        vectors++; if (tx_p_data !== 8'hA5) begin fails++; $display("FAIL single_data got=%h exp=a5", tx_p_data); end
        vectors++; if (gnt_id !== 2'd2)     begin fails++; $display("FAIL single_gnt_id got=%0d exp=2", gnt_id); end
        vectors++; if (active !== 1'b1)     begin fails++; $display("FAIL single_active got=%b exp=1", active); end
        vectors++; if (req_ready !== 4'b0)  begin fails++; $display("FAIL single_ready_launch got=%b exp=0000", req_ready); end
        act = 1;
        for (int c = 0; c < 30; c++) begin
            tick();
            @(negedge clk);
            if (!active) break;
            act++;
        end
        tick();
        vectors++; if (act != 13)               begin fails++; $display("FAIL single_active_len got=%0d exp=13", act); end
        vectors++; if (n_launch - n0 != 1)      begin fails++; $display("FAIL single_strobes got=%0d exp=1", n_launch - n0); end
        vectors++; if (rdy_cnt[2] - r0 != 1)    begin fails++; $display("FAIL single_ready_pulses got=%0d exp=1", rdy_cnt[2] - r0); end
        vectors++; if (tx_p_data !== 8'hA5)     begin fails++; $display("FAIL single_data_hold got=%h exp=a5", tx_p_data); end
    endtask

    task automatic test_round_robin();
        int n0;
        int seq [4];
        logic [3:0] acc;
        logic [1:0] eid;
        logic [7:0] ed;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n0 = n_launch;
        for (int i = 0; i < 4; i++) begin
            seq[i] = 0;
            data[i] = 8'(i * 16);
        end
        req_valid = 4'b1111;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            tick();
            for (int i = 0; i < 4; i++) if (acc[i]) begin
                seq[i]++;
                data[i[1:0]] = 8'(i * 16 + seq[i]);
                if (seq[i] == 2) req_valid[i[1:0]] = 1'b0;
            end
            if (n_launch - n0 == 8 && !active && !tx_busy) break;
        end
        vectors++; if (n_launch - n0 != 8) begin fails++; $display("FAIL rr_count got=%0d exp=8", n_launch - n0); end
        for (int k = 0; k < 8; k++) begin
            eid = 2'(k % 4);
            ed = 8'((k % 4) * 16 + k / 4);
            vectors++; if (log_id[n0+k] !== eid)  begin fails++; $display("FAIL rr_id[%0d] got=%0d exp=%0d", k, log_id[n0+k], eid); end
            vectors++; if (log_data[n0+k] !== ed) begin fails++; $display("FAIL rr_data[%0d] got=%h exp=%h", k, log_data[n0+k], ed); end
        end
    endtask

    task automatic test_timeout();
        int n0, e0;
        bit ok;
        no_busy = 1'b1;
        n0 = n_launch;
        e0 = err_cnt;
        data[0] = 8'h3C;
        req_valid[0] = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            ok = req_ready[0];
            tick();
        end
        req_valid[0] = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        vectors++; if (!ok)                      begin fails++; $display("FAIL timeout_accept got=0 exp=1"); end
        vectors++; if (err_cnt - e0 != 1)        begin fails++; $display("FAIL timeout_err_pulses got=%0d exp=1", err_cnt - e0); end
        vectors++; if (err_cyc - log_cyc[n0] != 5) begin fails++; $display("FAIL timeout_err_delay got=%0d exp=5", err_cyc - log_cyc[n0]); end
        vectors++; if (n_launch - n0 != 1)       begin fails++; $display("FAIL timeout_strobes got=%0d exp=1", n_launch - n0); end
        vectors++; if (active !== 1'b0)          begin fails++; $display("FAIL timeout_active got=%b exp=0", active); end
        no_busy = 1'b0;
        data[2] = 8'h77;
        req_valid[2] = 1'b1;
        @(negedge clk);
        vectors++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL timeout_next_ready got=%b exp=0100", req_ready); end
        tick();
        req_valid[2] = 1'b0;
        @(negedge clk);
        vectors++; if (tx_dv !== 1'b1)      begin fails++; $display("FAIL timeout_next_dv got=%b exp=1", tx_dv); end
        vectors++; if (tx_p_data !== 8'h77) begin fails++; $display("FAIL timeout_next_data got=%h exp=77", tx_p_data); end
        tick();
        wait_idle("timeout");
    endtask

    task automatic test_busy_hold();
        int n0, r1;
        n0 = n_launch;
        r1 = rdy_cnt[1];
        force_busy = 1'b1;
        data[1] = 8'h5A;
        req_valid[1] = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        vectors++; if (rdy_cnt[1] - r1 != 0) begin fails++; $display("FAIL busy_ready got=%0d exp=0", rdy_cnt[1] - r1); end
        vectors++; if (n_launch - n0 != 0)   begin fails++; $display("FAIL busy_strobes got=%0d exp=0", n_launch - n0); end
        force_busy = 1'b0;
        @(negedge clk);
        vectors++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL busy_release_ready got=%b exp=0010", req_ready); end
        tick();
        req_valid[1] = 1'b0;
        @(negedge clk);
        vectors++; if (tx_dv !== 1'b1)      begin fails++; $display("FAIL busy_release_dv got=%b exp=1", tx_dv); end
        vectors++; if (tx_p_data !== 8'h5A) begin fails++; $display("FAIL busy_release_data got=%h exp=5a", tx_p_data); end
        tick();
        wait_idle("busy");
    endtask

    task automatic test_reset_mid();
        int e0;
        bit low;
        e0 = err_cnt;
        data[2] = 8'hC3;
        req_valid[2] = 1'b1;
        tick();
        req_valid[2] = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        @(negedge clk);
        vectors++; if (active !== 1'b1 || tx_busy !== 1'b1) begin fails++; $display("FAIL mid_frame got=%b%b exp=11", active, tx_busy); end
        tick();
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        vectors++; if (active !== 1'b0)     begin fails++; $display("FAIL mid_rst_active got=%b exp=0", active); end
        vectors++; if (tx_p_data !== 8'h00) begin fails++; $display("FAIL mid_rst_data got=%h exp=00", tx_p_data); end
        vectors++; if (gnt_id !== 2'd0)     begin fails++; $display("FAIL mid_rst_gnt_id got=%0d exp=0", gnt_id); end
        vectors++; if (tx_dv !== 1'b0)      begin fails++; $display("FAIL mid_rst_dv got=%b exp=0", tx_dv); end
        vectors++; if (tx_err !== 1'b0)     begin fails++; $display("FAIL mid_rst_err got=%b exp=0", tx_err); end
        tick();
        rst_n = 1'b1;
        low = 1'b0;
        for (int c = 0; c < 30 && !low; c++) begin
            @(negedge clk);
            low = !tx_busy;
            tick();
        end
        vectors++; if (!low) begin fails++; $display("FAIL mid_busy_fall got=1 exp=0"); end
        data[0] = 8'h11;
        data[3] = 8'h33;
        req_valid = 4'b1001;
        @(negedge clk);
        vectors++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL mid_prio_ready got=%b exp=0001", req_ready); end
        tick();
        req_valid = 4'b0000;
        @(negedge clk);
        vectors++; if (gnt_id !== 2'd0)     begin fails++; $display("FAIL mid_prio_gnt_id got=%0d exp=0", gnt_id); end
        vectors++; if (tx_p_data !== 8'h11) begin fails++; $display("FAIL mid_prio_data got=%h exp=11", tx_p_data); end
        vectors++; if (err_cnt != e0)       begin fails++; $display("FAIL mid_no_err got=%0d exp=%0d", err_cnt, e0); end
        tick();
        wait_idle("mid");
    endtask

    task automatic test_withdraw();
        int r1, r3;
        r1 = rdy_cnt[1];
        r3 = rdy_cnt[3];
        force_busy = 1'b1;
        data[1] = 8'h44;
        data[3] = 8'h99;
        req_valid = 4'b1010;
        for (int c = 0; c < 3; c++) tick();
        req_valid[1] = 1'b0;
        tick();
        force_busy = 1'b0;
        @(negedge clk);
        vectors++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL withdraw_ready got=%b exp=1000", req_ready); end
        tick();
        req_valid[3] = 1'b0;
        @(negedge clk);
        vectors++; if (gnt_id !== 2'd3)     begin fails++; $display("FAIL withdraw_gnt_id got=%0d exp=3", gnt_id); end
        vectors++; if (tx_p_data !== 8'h99) begin fails++; $display("FAIL withdraw_data got=%h exp=99", tx_p_data); end
        tick();
        wait_idle("withdraw");
        vectors++; if (rdy_cnt[1] - r1 != 0) begin fails++; $display("FAIL withdraw_r1_ready got=%0d exp=0", rdy_cnt[1] - r1); end
        vectors++; if (rdy_cnt[3] - r3 != 1) begin fails++; $display("FAIL withdraw_r3_ready got=%0d exp=1", rdy_cnt[3] - r3); end
    endtask

    initial begin
        vectors = 0;
        fails = 0;
        force_busy = 1'b0;
        no_busy = 1'b0;
        rst_n = 1'b0;
        req_valid = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_busy_hold();
        test_reset_mid();
        test_withdraw();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
